// File: rtl/axistream_unpack_pkg.sv
// rtl/axistream_unpack_pkg.sv - shared width and beat-slice helpers for the pack/unpack pair
package axistream_unpack_pkg;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Which wide-word slice carries beat number idx.
  function automatic int beat_slice(input int idx, input int num_pack, input bit big_endian);
    return big_endian ? (num_pack - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/axistream_unpack.sv
// rtl/axistream_unpack.sv - splits one wide stream word into NUM_PACK narrow beats
module axistream_unpack
  import axistream_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           src_tvalid,
  output logic                           src_tready,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata,
  input  logic                           src_tlast,
  output logic                           dest_tvalid,
  input  logic                           dest_tready,
  output logic [DATA_WIDTH-1:0]          dest_tdata,
  output logic                           dest_tlast
);

  localparam int IDX_W = clog2_min1(NUM_PACK);
  localparam int WIDE_W = DATA_WIDTH * NUM_PACK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

  logic [WIDE_W-1:0]     hold_data;
  logic                  hold_last;
  logic                  full;
  logic [IDX_W-1:0]      index;
  logic                  last_beat;
  logic                  accept;
  logic                  xfer;
  logic [IDX_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] slices [NUM_PACK];

  assign last_beat = (index == LAST_IDX);
  // A new word may land in the same cycle the final beat of the old one leaves.
  assign src_tready = !rst && (!full || (dest_tready && last_beat));
  assign accept = src_tvalid && src_tready;
  assign xfer = full && dest_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      full      <= 1'b0;
      index     <= '0;
    end else if (accept) begin
      hold_data <= src_tdata;
      hold_last <= src_tlast;
      full      <= 1'b1;
      index     <= '0;
    end else if (xfer) begin
      if (last_beat) begin
        index <= '0;
        full  <= 1'b0;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PACK; g++) begin : g_slice
    assign slices[g] = hold_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel         = IDX_W'(beat_slice(int'(index), NUM_PACK, BIG_ENDIAN));
  assign dest_tdata  = slices[sel];
  assign dest_tvalid = full;
  assign dest_tlast  = full && hold_last && last_beat;

endmodule

// File: tb/tb_axistream_unpack.sv
// tb/tb_axistream_unpack.sv - scoreboard bench for axistream_unpack, LE and BE instances
module tb_axistream_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        src_tvalid = 1'b0;
  logic        src_tready;
  logic [31:0] src_tdata = '0;
  logic        src_tlast = 1'b0;
  logic        dest_tvalid;
  logic        dest_tready = 1'b0;
  logic [7:0]  dest_tdata;
  logic        dest_tlast;

  logic        b_src_tvalid = 1'b0;
  logic        b_src_tready;
  logic [31:0] b_src_tdata = '0;
  logic        b_src_tlast = 1'b0;
  logic        b_dest_tvalid;
  logic        b_dest_tready = 1'b0;
  logic [7:0]  b_dest_tdata;
  logic        b_dest_tlast;

  int checks = 0;
  int failures = 0;
  int xfer_count = 0;
  bit rand_ready = 1'b0;

  logic [8:0] le_q[$];
  logic [8:0] be_q[$];

  always #5 clk = ~clk;

  axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata), .src_tlast(src_tlast),
    .dest_tvalid(dest_tvalid), .dest_tready(dest_tready), .dest_tdata(dest_tdata), .dest_tlast(dest_tlast)
  );

  axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst),
    .src_tvalid(b_src_tvalid), .src_tready(b_src_tready), .src_tdata(b_src_tdata), .src_tlast(b_src_tlast),
    .dest_tvalid(b_dest_tvalid), .dest_tready(b_dest_tready), .dest_tdata(b_dest_tdata), .dest_tlast(b_dest_tlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte order is the word's bytes low-to-high (LE) or high-to-low (BE);
  // tlast rides only on the fourth byte of a tlast word.
  task automatic push_word(input bit be, input logic [31:0] w, input bit last);
    logic [31:0] v;
    logic [7:0]  b;
    v = w;
    for (int i = 0; i < 4; i++) begin
      b = be ? v[31-8*i -: 8] : v[8*i +: 8];
      if (be) be_q.push_back({last && (i == 3), b});
      else    le_q.push_back({last && (i == 3), b});
    end
  endtask

  task automatic send_word(input bit be, input logic [31:0] w, input bit last);
    bit got;
    got = 1'b0;
    if (be) begin b_src_tvalid = 1'b1; b_src_tdata = w; b_src_tlast = last; end
    else    begin src_tvalid = 1'b1; src_tdata = w; src_tlast = last; end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if ((be ? b_src_tready : src_tready) === 1'b1) got = 1'b1;
    end
    chk("src_accept_timeout", {31'd0, got}, 32'd1);
    if (got) push_word(be, w, last);
    @(posedge clk); #1;
    if (be) b_src_tvalid = 1'b0;
    else    src_tvalid = 1'b0;
  endtask

  // Monitor for the LE instance: scoreboard pop plus hold-while-stalled rule.
  bit         le_stall = 1'b0;
  logic [8:0] le_stall_v;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      le_stall = 1'b0;
    end else begin
      if (le_stall) begin
        chk("le_stall_valid", {31'd0, dest_tvalid}, 32'd1);
        chk("le_stall_beat", {23'd0, dest_tlast, dest_tdata}, {23'd0, le_stall_v});
      end
      if (dest_tvalid && dest_tready) begin
        xfer_count++;
        if (le_q.size() == 0) begin
          chk("le_unexpected_beat", {23'd0, dest_tlast, dest_tdata}, 32'hffffffff);
        end else begin
          e = le_q.pop_front();
          chk("le_beat", {23'd0, dest_tlast, dest_tdata}, {23'd0, e});
        end
      end
      le_stall = dest_tvalid && !dest_tready;
      le_stall_v = {dest_tlast, dest_tdata};
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && b_dest_tvalid && b_dest_tready) begin
      if (be_q.size() == 0) begin
        chk("be_unexpected_beat", {23'd0, b_dest_tlast, b_dest_tdata}, 32'hffffffff);
      end else begin
        e = be_q.pop_front();
        chk("be_beat", {23'd0, b_dest_tlast, b_dest_tdata}, {23'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 dest_tready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    int base;
    logic [31:0] w;
    bit l;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_tready", {31'd0, src_tready}, 32'd0);
    chk("rst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);
    chk("rst_dest_tdata", {24'd0, dest_tdata}, 32'd0);
    chk("rst_dest_tlast", {31'd0, dest_tlast}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_src_tready", {31'd0, src_tready}, 32'd1);
    chk("idle_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);

    // Big-endian word
    b_dest_tready = 1'b1;
    @(posedge clk); #1;
    send_word(1'b1, 32'hDDCCBBAA, 1'b1);
    send_word(1'b1, 32'h44332211, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("be_drained", be_q.size(), 0);

    // Single LE word: first beat next cycle, src_tready low for three cycles
    dest_tready = 1'b1;
    send_word(1'b0, 32'hDDCCBBAA, 1'b1);
    @(negedge clk);
    chk("le_first_beat_valid", {31'd0, dest_tvalid}, 32'd1);
    chk("le_tready_low_0", {31'd0, src_tready}, 32'd0);
    @(negedge clk);
    chk("le_tready_low_1", {31'd0, src_tready}, 32'd0);
    @(negedge clk);
    chk("le_tready_low_2", {31'd0, src_tready}, 32'd0);
    @(negedge clk);
    chk("le_tready_on_last", {31'd0, src_tready}, 32'd1);
    @(posedge clk); #1;
    chk("le_single_drained", le_q.size(), 0);

    // Back-to-back words: eight beats on eight consecutive cycles
    send_word(1'b0, 32'h03020100, 1'b0);
    base = xfer_count;
    send_word(1'b0, 32'h07060504, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_beats_in_8_cycles", xfer_count - base, 8);
    @(posedge clk); #1;

    // Reset after beat BB: CC and DD must never appear
    send_word(1'b0, 32'hDDCCBBAA, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    dest_tready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);
    chk("midrst_dest_tlast", {31'd0, dest_tlast}, 32'd0);
    chk("midrst_dest_tdata", {24'd0, dest_tdata}, 32'd0);
    chk("midrst_src_tready", {31'd0, src_tready}, 32'd0);
    chk("midrst_beats_left", le_q.size(), 2);
    le_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dest_tready = 1'b1;
    send_word(1'b0, 32'h44332211, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_drained", le_q.size(), 0);

    // Random words with ~50% dest stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      w = $urandom;
      l = ($urandom_range(0, 3) == 0);
      send_word(1'b0, w, l);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    dest_tready = 1'b1;
    for (int n = 0; n < 100 && le_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("random_drained", le_q.size(), 0);
    chk("final_be_empty", be_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
